// File: rtl/regfile_2w2r_clr.sv
// Dual-write, dual-read register file with optional zero register, write-to-read
// bypass, and a one-entry-per-cycle clear engine that runs after reset or on request.
module regfile_2w2r_clr #(
  parameter int ADDR    = 5,
  parameter int NUM     = 32,
  parameter int SIZE    = 32,
  parameter bit BYPASS  = 1'b1,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic            Clk,
  input  logic            reset,
  input  logic [ADDR-1:0] R_Addr_A,
  input  logic [ADDR-1:0] R_Addr_B,
  input  logic            W_En_A,
  input  logic [ADDR-1:0] W_Addr_A,
  input  logic [SIZE-1:0] W_Data_A,
  input  logic            W_En_B,
  input  logic [ADDR-1:0] W_Addr_B,
  input  logic [SIZE-1:0] W_Data_B,
  input  logic            Clr_Req,
  output logic [SIZE-1:0] R_Data_A,
  output logic [SIZE-1:0] R_Data_B,
  output logic            Busy,
  output logic            Clr_Done
);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  localparam logic [ADDR:0]   NUM_W = (ADDR + 1)'(NUM);
  localparam logic [ADDR-1:0] LAST  = ADDR'(NUM - 1);

  state_t          state;
  logic [ADDR-1:0] idx;
  logic [SIZE-1:0] regs [NUM];

  logic wr_a_ok;
  logic wr_b_ok;
  logic clr_we;

  // Address is storable: inside the array and not the hardwired-zero entry.
  function automatic logic addr_ok(input logic [ADDR-1:0] a);
    return ({1'b0, a} < NUM_W) && !(ZERO_R0 && (a == '0));
  endfunction

  assign wr_a_ok = W_En_A && !Busy && addr_ok(W_Addr_A);
  assign wr_b_ok = W_En_B && !Busy && addr_ok(W_Addr_B);
  assign clr_we  = (state == CLEAR) && !reset;

  // Control FSM; Busy and Clr_Done are registered alongside the state.
  always_ff @(posedge Clk) begin
    Clr_Done <= 1'b0;
    if (reset) begin
      state <= CLEAR;
      idx   <= '0;
      Busy  <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (Clr_Req) begin
            state <= CLEAR;
            idx   <= '0;
            Busy  <= 1'b1;
          end
        end
        CLEAR: begin
          if (idx == LAST) begin
            state    <= IDLE;
            Busy     <= 1'b0;
            Clr_Done <= 1'b1;
          end else begin
            idx <= idx + ADDR'(1);
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  // NOTE: the array has no reset term; contents are zeroed by the clear engine
  // instead, which keeps the storage plain enable-only flops.
  always_ff @(posedge Clk) begin
    if (clr_we) begin
      regs[idx] <= '0;
    end else if (!reset) begin
      if (wr_a_ok) regs[W_Addr_A] <= W_Data_A;
      // Port B is written last so it wins an address collision.
      if (wr_b_ok) regs[W_Addr_B] <= W_Data_B;
    end
  end

  function automatic logic [SIZE-1:0] read_port(input logic [ADDR-1:0] a);
    logic [SIZE-1:0] d;
    d = '0;
    if (!Busy && addr_ok(a)) begin
      d = regs[a];
      if (BYPASS) begin
        if (wr_b_ok && (W_Addr_B == a))      d = W_Data_B;
        else if (wr_a_ok && (W_Addr_A == a)) d = W_Data_A;
      end
    end
    return d;
  endfunction

  // NOTE: every combinational output gets a full assignment on every path so
  // no latch is inferred.
  always_comb begin
    R_Data_A = read_port(R_Addr_A);
    R_Data_B = read_port(R_Addr_B);
  end

endmodule

// File: tb/tb_regfile_2w2r_clr.sv
// Directed bench for regfile_2w2r_clr: default, no-bypass and NUM=24 instances
// share one stimulus stream; expectations flow through a scoreboard queue.
module tb_regfile_2w2r_clr;

  logic        Clk = 1'b0;
  logic        reset;
  logic [4:0]  R_Addr_A, R_Addr_B, W_Addr_A, W_Addr_B;
  logic        W_En_A, W_En_B, Clr_Req;
  logic [31:0] W_Data_A, W_Data_B;

  logic [31:0] rda, rdb, nb_rda, nb_rdb, s_rda, s_rdb;
  logic        busy, done, nb_busy, nb_done, s_busy, s_done;

  regfile_2w2r_clr dut (
    .Clk(Clk), .reset(reset), .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B),
    .W_En_A(W_En_A), .W_Addr_A(W_Addr_A), .W_Data_A(W_Data_A),
    .W_En_B(W_En_B), .W_Addr_B(W_Addr_B), .W_Data_B(W_Data_B),
    .Clr_Req(Clr_Req), .R_Data_A(rda), .R_Data_B(rdb), .Busy(busy), .Clr_Done(done)
  );

  regfile_2w2r_clr #(.BYPASS(1'b0)) dut_nb (
    .Clk(Clk), .reset(reset), .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B),
    .W_En_A(W_En_A), .W_Addr_A(W_Addr_A), .W_Data_A(W_Data_A),
    .W_En_B(W_En_B), .W_Addr_B(W_Addr_B), .W_Data_B(W_Data_B),
    .Clr_Req(Clr_Req), .R_Data_A(nb_rda), .R_Data_B(nb_rdb), .Busy(nb_busy), .Clr_Done(nb_done)
  );

  regfile_2w2r_clr #(.NUM(24)) dut_s (
    .Clk(Clk), .reset(reset), .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B),
    .W_En_A(W_En_A), .W_Addr_A(W_Addr_A), .W_Data_A(W_Data_A),
    .W_En_B(W_En_B), .W_Addr_B(W_Addr_B), .W_Data_B(W_Data_B),
    .Clr_Req(Clr_Req), .R_Data_A(s_rda), .R_Data_B(s_rdb), .Busy(s_busy), .Clr_Done(s_done)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %h, nothing expected", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic quiet();
    W_En_A  = 1'b0;
    W_En_B  = 1'b0;
    Clr_Req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int fall, fall24, dcnt, dedge;

    reset = 1'b1;
    R_Addr_A = '0; R_Addr_B = '0; W_Addr_A = '0; W_Addr_B = '0;
    W_Data_A = '0; W_Data_B = '0;
    quiet();

    // 1: reset, then a full post-reset clear
    tick();
    tick();
    push("rst_busy", 32'd1); check(busy);
    push("rst_done", 32'd0); check(done);
    reset = 1'b0;
    R_Addr_A = 5'd5;
    fall = 0; fall24 = 0; dcnt = 0; dedge = 0;
    for (int e = 1; e <= 40; e++) begin
      tick();
      if (done) begin dcnt++; dedge = e; end
      if (!s_busy && fall24 == 0) fall24 = e;
      if (e == 5) begin push("busy_read", 32'd0); check(rda); end
      if (!busy) begin fall = e; break; end
    end
    push("rst_fall_edge", 32'd32); check(fall);
    push("rst_fall_edge24", 32'd24); check(fall24);
    push("rst_done_cnt", 32'd1); check(dcnt);
    push("rst_done_edge", 32'd32); check(dedge);
    tick();
    push("rst_done_width", 32'd0); check(done);
    for (int a = 0; a < 32; a++) begin
      R_Addr_A = 5'(a);
      #1;
      push($sformatf("rst_zero_%0d", a), 32'd0); check(rda);
    end

    // 2: separate A and B writes
    W_En_A = 1'b1; W_Addr_A = 5'd5; W_Data_A = 32'hDEADBEEF;
    tick(); quiet();
    W_En_B = 1'b1; W_Addr_B = 5'd9; W_Data_B = 32'h12345678;
    tick(); quiet();
    R_Addr_A = 5'd5; R_Addr_B = 5'd9;
    #1;
    push("wr_a5", 32'hDEADBEEF); check(rda);
    push("wr_b9", 32'h12345678); check(rdb);
    push("wr_b9_s", 32'h12345678); check(s_rdb);

    // 3: same-address dual write, bypass vs no bypass
    W_En_A = 1'b1; W_Addr_A = 5'd7; W_Data_A = 32'h11111111;
    W_En_B = 1'b1; W_Addr_B = 5'd7; W_Data_B = 32'h22222222;
    R_Addr_A = 5'd7;
    #1;
    push("byp_pre", 32'h22222222); check(rda);
    push("nobyp_pre", 32'h00000000); check(nb_rda);
    tick(); quiet();
    push("byp_post", 32'h22222222); check(rda);
    push("nobyp_post", 32'h22222222); check(nb_rda);
    W_En_A = 1'b1; W_Addr_A = 5'd12; W_Data_A = 32'h5A5A5A5A;
    R_Addr_B = 5'd12;
    #1;
    push("byp_a_only", 32'h5A5A5A5A); check(rdb);
    push("nobyp_a_only", 32'h00000000); check(nb_rdb);
    tick(); quiet();

    // 4: register 0 and out-of-range writes
    W_En_A = 1'b1; W_Addr_A = 5'd0; W_Data_A = 32'hFFFFFFFF;
    W_En_B = 1'b1; W_Addr_B = 5'd0; W_Data_B = 32'hFFFFFFFF;
    R_Addr_A = 5'd0; R_Addr_B = 5'd0;
    #1;
    push("r0_pre_a", 32'd0); check(rda);
    push("r0_pre_b", 32'd0); check(rdb);
    tick(); quiet();
    push("r0_post_a", 32'd0); check(rda);
    push("r0_post_nb", 32'd0); check(nb_rda);
    W_En_A = 1'b1; W_Addr_A = 5'd30; W_Data_A = 32'hCAFEF00D;
    W_En_B = 1'b1; W_Addr_B = 5'd23; W_Data_B = 32'h0BADC0DE;
    R_Addr_A = 5'd30; R_Addr_B = 5'd23;
    #1;
    push("oor_pre_s", 32'd0); check(s_rda);
    push("last_byp_s", 32'h0BADC0DE); check(s_rdb);
    push("a30_byp", 32'hCAFEF00D); check(rda);
    tick(); quiet();
    push("oor_post_s", 32'd0); check(s_rda);
    push("last_post_s", 32'h0BADC0DE); check(s_rdb);
    push("a30_post", 32'hCAFEF00D); check(rda);

    // 5: requested clear with a same-edge write and an ignored second request
    for (int i = 1; i < 32; i++) begin
      W_En_A = 1'b1; W_Addr_A = 5'(i); W_Data_A = 32'h10000000 | i;
      tick();
    end
    quiet();
    R_Addr_A = 5'd17;
    #1;
    push("fill_17", 32'h10000011); check(rda);
    Clr_Req = 1'b1;
    W_En_A = 1'b1; W_Addr_A = 5'd3; W_Data_A = 32'hAAAAAAAA;
    tick(); quiet();
    push("req_busy", 32'd1); check(busy);
    fall = 0; fall24 = 0; dcnt = 0; dedge = 0;
    R_Addr_A = 5'd5;
    for (int e = 1; e <= 40; e++) begin
      if (e == 5) begin #1; push("req_busy_read", 32'd0); check(rda); end
      if (e == 10) Clr_Req = 1'b1;
      if (e == 20) begin W_En_A = 1'b1; W_Addr_A = 5'd1; W_Data_A = 32'h00000077; end
      tick(); quiet();
      if (done) begin dcnt++; dedge = e; end
      if (!s_busy && fall24 == 0) fall24 = e;
      if (!busy) begin fall = e; break; end
    end
    push("req_fall_edge", 32'd32); check(fall);
    push("req_fall_edge24", 32'd24); check(fall24);
    push("req_done_cnt", 32'd1); check(dcnt);
    push("req_done_edge", 32'd32); check(dedge);
    for (int a = 0; a < 32; a++) begin
      R_Addr_A = 5'(a);
      #1;
      push($sformatf("req_zero_%0d", a), 32'd0); check(rda);
    end
    R_Addr_B = 5'd1;
    #1;
    push("busy_wr_dropped_s", 32'd0); check(s_rdb);

    // 6: reset in the middle of a requested clear
    Clr_Req = 1'b1;
    tick(); quiet();
    dcnt = 0;
    for (int e = 1; e <= 15; e++) begin
      if (e == 15) reset = 1'b1;
      tick();
      if (done) dcnt++;
    end
    reset = 1'b0;
    push("mid_rst_busy", 32'd1); check(busy);
    fall = 0; fall24 = 0;
    for (int e = 1; e <= 40; e++) begin
      tick();
      if (done) dcnt++;
      if (!s_busy && fall24 == 0) fall24 = e;
      if (!busy) begin fall = e; break; end
    end
    tick();
    if (done) dcnt++;
    push("mid_rst_fall", 32'd32); check(fall);
    push("mid_rst_fall24", 32'd24); check(fall24);
    push("mid_rst_done_cnt", 32'd1); check(dcnt);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
